// File: rtl/bus_responder.sv
// Target side of the CPU byte bus: internal byte RAM plus memory-mapped UART FIFOs,
// program-stop flag and (with IO_CYCLE_COUNTER_EN defined) a free-running cycle counter.
module bus_responder #(
    parameter int RAM_AW   = 17,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_end,
    output logic        tx_overflow
);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam logic [RX_PW:0] RX_FULL   = (RX_PW+1)'(RX_DEPTH);
    localparam logic [TX_PW:0] TX_FULL   = (TX_PW+1)'(TX_DEPTH);
    localparam logic [TX_PW:0] TX_RDY_LIM = (TX_PW+1)'(TX_DEPTH - 2);

    logic [7:0]       ram [2**RAM_AW];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RX_PW-1:0] rx_wr, rx_rd;
    logic [TX_PW-1:0] tx_wr, tx_rd;
    logic [RX_PW:0]   rx_count, rx_count_nxt;
    logic [TX_PW:0]   tx_count, tx_count_nxt;

    logic [RAM_AW-1:0] ram_a;
    logic [15:0]       io_off;
    logic              io_sel, rx_push, rx_pop, tx_wr_req, tx_push, tx_pop;
    logic [7:0]        tx_push_data, io_rd_p0;
    logic [7:0]        ram_rd_p1, io_rd_p1;
    logic              src_ram_p1;
    logic              unused_addr_bits;

    // ---- stage p0: decode of the access presented this cycle ----
    assign ram_a            = mem_a[RAM_AW-1:0];
    assign io_sel           = (mem_a[17:16] == 2'b11);
    assign io_off           = mem_a[15:0];
    assign unused_addr_bits = ^mem_a[31:18];

    assign rx_ready     = (rx_count < RX_FULL);
    assign rx_push      = rx_valid && rx_ready;
    assign rx_pop       = !mem_wr && io_sel && (io_off == 16'h0000) && (rx_count != '0);
    assign tx_wr_req    = mem_wr && io_sel &&
                          (((io_off == 16'h0000) && (mem_dout != 8'h00)) || (io_off == 16'h0004));
    assign tx_push      = tx_wr_req && (tx_count != TX_FULL);
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_push_data = (io_off == 16'h0004) ? 8'h00 : mem_dout;
    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_valid ? tx_mem[tx_rd] : 8'h00;

    assign rx_count_nxt = rx_count + (RX_PW+1)'(rx_push) - (RX_PW+1)'(rx_pop);
    assign tx_count_nxt = tx_count + (TX_PW+1)'(tx_push) - (TX_PW+1)'(tx_pop);

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cyc_cnt;
    logic [23:0] snap_hi;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cyc_cnt <= '0;
            snap_hi <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (!mem_wr && io_sel && (io_off == 16'h0004))
                snap_hi <= cyc_cnt[31:8];
        end
    end
`endif

    always_comb begin
        io_rd_p0 = 8'h00;
        case (io_off)
            16'h0000: io_rd_p0 = (rx_count != '0) ? rx_mem[rx_rd] : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
            16'h0004: io_rd_p0 = cyc_cnt[7:0];
            16'h0005: io_rd_p0 = snap_hi[7:0];
            16'h0006: io_rd_p0 = snap_hi[15:8];
            16'h0007: io_rd_p0 = snap_hi[23:16];
`endif
            default:  io_rd_p0 = 8'h00;
        endcase
    end

    // ---- stage p1: registered state and read data ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_count    <= '0;
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_count    <= '0;
            rdy_out     <= 1'b1;
            program_end <= 1'b0;
            tx_overflow <= 1'b0;
            src_ram_p1  <= 1'b0;
            io_rd_p1    <= 8'h00;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            rx_count <= rx_count_nxt;
            tx_count <= tx_count_nxt;
            // rdy lags a cycle, so one write may still land after it drops: keep two slots spare
            rdy_out  <= (tx_count_nxt < TX_RDY_LIM);
            if (mem_wr && io_sel && (io_off == 16'h0004)) program_end <= 1'b1;
            if (tx_wr_req && !tx_push)                     tx_overflow <= 1'b1;
            if (!mem_wr) begin
                src_ram_p1 <= !io_sel;
                if (io_sel) io_rd_p1 <= io_rd_p0;
            end
        end
    end

    // Storage is never reset; pointers and counts alone define FIFO contents.
    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel)  ram[ram_a] <= mem_dout;
        if (!mem_wr && !io_sel) ram_rd_p1  <= ram[ram_a];
        if (rx_push) rx_mem[rx_wr] <= rx_data;
        if (tx_push) tx_mem[tx_wr] <= tx_push_data;
    end

    assign mem_din = src_ram_p1 ? ram_rd_p1 : io_rd_p1;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios plus a randomized run
// checked against a queue-based model of the bus, FIFOs and RAM.
module tb_bus_responder;
    localparam int RX_DEPTH = 8;
    localparam int TX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        program_end;
    logic        tx_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc;   // cycles elapsed since reset release = expected counter value

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] ram_m[int];

    bus_responder #(.RAM_AW(17), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .rdy_out(rdy_out), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .program_end(program_end), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // One bus access: drive at a falling edge, return at the next falling edge.
    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        mem_a = a; mem_wr = w; mem_dout = d;
        @(negedge clk);
    endtask

    task automatic idle();
        bus(32'h100, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rst_mem_din got=%h exp=00", mem_din); end
        n_cmp++; if (rdy_out !== 1'b1) begin n_bad++; $display("FAIL rst_rdy got=%b exp=1", rdy_out); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
        n_cmp++; if (program_end !== 1'b0 || tx_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_flags got=%b%b exp=00", program_end, tx_overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_counter();
        int unsigned c;
        logic [31:0] cv;
`ifdef IO_CYCLE_COUNTER_EN
        for (int i = 0; i < 2000 && cyc != 32'h1FF; i++) idle();
        n_cmp++; if (cyc != 32'h1FF) begin n_bad++; $display("FAIL cnt_wait got=%0d exp=511", cyc); end
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hFF) begin n_bad++; $display("FAIL cnt_b0 got=%h exp=ff", mem_din); end
        bus(32'h30005, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h01) begin n_bad++; $display("FAIL cnt_b1 got=%h exp=01", mem_din); end
        bus(32'h30006, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL cnt_b2 got=%h exp=00", mem_din); end
        bus(32'h30007, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL cnt_b3 got=%h exp=00", mem_din); end
        repeat ($urandom_range(5, 300)) idle();
        c = cyc;
        cv = c;
        for (int k = 0; k < 4; k++) begin
            bus(32'h30004 + k, 1'b0, 8'h00);
            n_cmp++; if (mem_din !== cv[8*k +: 8]) begin n_bad++; $display("FAIL cnt_rand_b%0d got=%h exp=%h", k, mem_din, cv[8*k +: 8]); end
        end
`else
        c = 0;
        cv = 32'h0;
        repeat (20) idle();
        for (int k = 0; k < 4; k++) begin
            bus(32'h30004 + k, 1'b0, 8'h00);
            n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL nocnt_b%0d got=%h exp=00 (%0d %h)", k, mem_din, c, cv); end
        end
`endif
    endtask

    task automatic test_ram();
        bus(32'h100, 1'b1, 8'hA5); ram_m[32'h100] = 8'hA5;
        bus(32'h100, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_readback got=%h exp=a5", mem_din); end
        bus(32'h1FFFF, 1'b1, 8'h3C); ram_m[32'h1FFFF] = 8'h3C;
        n_cmp++; if (mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_write_hold got=%h exp=a5", mem_din); end
        bus(32'h1FFFF, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h3C) begin n_bad++; $display("FAIL ram_top got=%h exp=3c", mem_din); end
    endtask

    task automatic test_rx();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h00;
        rx_valid = 1'b1; rx_data = 8'h41; idle();
        rx_data = 8'h42; idle();
        rx_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus(32'h30000, 1'b0, 8'h00);
            n_cmp++; if (mem_din !== exp_b[k]) begin n_bad++; $display("FAIL rx_pop%0d got=%h exp=%h", k, mem_din, exp_b[k]); end
        end
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready got=%b exp=1", rx_ready); end
        // fill to depth: rx_ready must drop, then one pop frees a slot
        rx_valid = 1'b1;
        for (int k = 0; k < RX_DEPTH; k++) begin rx_data = 8'h60 + 8'(k); idle(); end
        rx_valid = 1'b0;
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_full got=%b exp=0", rx_ready); end
        for (int k = 0; k < RX_DEPTH; k++) begin
            bus(32'h30000, 1'b0, 8'h00);
            n_cmp++; if (mem_din !== 8'h60 + 8'(k)) begin n_bad++; $display("FAIL rx_drain%0d got=%h exp=%h", k, mem_din, 8'h60 + 8'(k)); end
        end
    endtask

    task automatic test_tx_backpressure();
        tx_ready = 1'b0;
        for (int k = 0; k < TX_DEPTH; k++) begin
            bus(32'h30000, 1'b1, 8'h10 + 8'(k));
            n_cmp++; if (rdy_out !== ((k + 1) < 6)) begin n_bad++; $display("FAIL tx_rdy_q%0d got=%b exp=%b", k + 1, rdy_out, (k + 1) < 6); end
        end
        n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL tx_no_ovf got=%b exp=0", tx_overflow); end
        bus(32'h30000, 1'b1, 8'hEE);
        n_cmp++; if (tx_overflow !== 1'b1) begin n_bad++; $display("FAIL tx_ovf got=%b exp=1", tx_overflow); end
        mem_a = 32'h100; mem_wr = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < TX_DEPTH; k++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(k)) begin n_bad++; $display("FAIL tx_out%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, 8'h10 + 8'(k)); end
            @(negedge clk);
        end
        n_cmp++; if (tx_valid !== 1'b0 || rdy_out !== 1'b1) begin n_bad++; $display("FAIL tx_drained got=%b/%b exp=0/1", tx_valid, rdy_out); end
    endtask

    task automatic test_tx_special();
        tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_zero_ignored got=%b exp=0", tx_valid); end
        bus(32'h30004, 1'b1, 8'h77);
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_bad++; $display("FAIL tx_end_byte got=%b/%h exp=1/00", tx_valid, tx_data); end
        n_cmp++; if (program_end !== 1'b1) begin n_bad++; $display("FAIL program_end got=%b exp=1", program_end); end
        tx_ready = 1'b1;
        idle();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_end_pop got=%b exp=0", tx_valid); end
    endtask

    task automatic test_random();
        logic [7:0] din_exp;
        logic       din_known, rdy_exp, rxv, txr;
        logic [7:0] d, rxd;
        logic [31:0] a;
        int op, idx, rx_pre, tx_pre;
        din_known = 1'b0; din_exp = 8'h00; rdy_exp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            n_cmp++; if (rx_ready !== (rxq.size() < RX_DEPTH)) begin n_bad++; $display("FAIL rnd_rx_ready@%0d got=%b exp=%b", n, rx_ready, rxq.size() < RX_DEPTH); end
            n_cmp++; if (tx_valid !== (txq.size() != 0) || tx_data !== ((txq.size() != 0) ? txq[0] : 8'h00)) begin
                n_bad++; $display("FAIL rnd_tx@%0d got=%b/%h exp=%b/%h", n, tx_valid, tx_data, txq.size() != 0, (txq.size() != 0) ? txq[0] : 8'h00); end
            n_cmp++; if (rdy_out !== rdy_exp) begin n_bad++; $display("FAIL rnd_rdy@%0d got=%b exp=%b", n, rdy_out, rdy_exp); end
            if (din_known) begin
                n_cmp++; if (mem_din !== din_exp) begin n_bad++; $display("FAIL rnd_din@%0d got=%h exp=%h", n, mem_din, din_exp); end
            end
            rx_pre = rxq.size(); tx_pre = txq.size();
            rxv = 1'($urandom_range(0, 1)); rxd = 8'($urandom);
            txr = 1'($urandom_range(0, 1));
            rx_valid = rxv; rx_data = rxd; tx_ready = txr;
            idx = $urandom_range(0, 15);
            a = (idx == 15) ? 32'h1FFFF : 32'h200 + 32'(idx) * 32'h111;
            d = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            op = $urandom_range(0, 99);
            if (op >= 80 && !rdy_exp) op = 0;
            if (op >= 30 && op < 55 && !ram_m.exists(a)) op = 0;
            if (txr && tx_pre > 0) void'(txq.pop_front());
            if (op < 30) begin
                mem_a = a; mem_wr = 1'b1; mem_dout = d; ram_m[a] = d;
            end else if (op < 55) begin
                mem_a = a; mem_wr = 1'b0; din_exp = ram_m[a]; din_known = 1'b1;
            end else if (op < 80) begin
                mem_a = 32'h30000; mem_wr = 1'b0;
                din_exp = (rx_pre > 0) ? rxq.pop_front() : 8'h00; din_known = 1'b1;
            end else begin
                mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = d;
                if (d != 8'h00) txq.push_back(d);
            end
            if (rxv && rx_pre < RX_DEPTH) rxq.push_back(rxd);
            rdy_exp = (TX_DEPTH - txq.size()) >= 3;
            @(negedge clk);
        end
        rx_valid = 1'b0; tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid_pop();
        rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin rx_data = 8'hB0 + 8'(k); idle(); end
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h55);
        mem_a = 32'h30000; mem_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL mid_rst_din got=%h exp=00", mem_din); end
        n_cmp++; if (rdy_out !== 1'b1 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy got=%b/%b exp=1/1", rdy_out, rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0 || tx_overflow !== 1'b0 || program_end !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_tx got=%b%b%b exp=000", tx_valid, tx_overflow, program_end); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rxq.delete(); txq.delete();
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL mid_rst_hold got=%h exp=00", mem_din); end
        bus(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rx_empty got=%h exp=00", mem_din); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tx_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        mem_a = 32'h100; mem_wr = 1'b0;
        @(negedge clk);
        test_reset();
        test_counter();
        test_ram();
        test_rx();
        test_tx_backpressure();
        test_tx_special();
        test_random();
        test_reset_mid_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
